uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DATA_BITS_MAX, default 9, SHALL set the widest supported character width (legal range 5-9).
REQ-002 Parameter FIFO_DEPTH, default 8, SHALL set the transmit FIFO depth in words (power of two, minimum 2).
REQ-003 clock_i  in  1  SHALL be the single clock; all logic samples on its rising edge.
REQ-004 reset_ni  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 write_i  in  1  SHALL request a push of data_i into the FIFO when high at a rising edge.
REQ-006 data_i  in  DATA_BITS_MAX  SHALL carry the character; bit 0 is sent first.
REQ-007 data_bits_i  in  4  SHALL give the character width.
REQ-008 parity_bit_i  in  1  SHALL enable the parity bit.
REQ-009 parity_even_i  in  1  SHALL select even parity (1) or odd parity (0).
REQ-010 two_stop_bits_i  in  1  SHALL select two stop bits (1) or one (0).
REQ-011 clock_divider_i  in  16  SHALL set the bit period to clock_divider_i+1 clocks.
REQ-012 serial_o  out  1  SHALL be the serial line, idle high.
REQ-013 busy_o  out  1  SHALL be high while a frame is on the line.
REQ-014 full_o / empty_o  out  1 each  SHALL reflect FIFO occupancy.
REQ-015 level_o  out  clog2(FIFO_DEPTH)+1  SHALL report the FIFO word count.
REQ-016 overflow_o  out  1  SHALL pulse high for one clock when a write is dropped.

Function
REQ-017 Push: a write at edge k SHALL make the word available to the FSM after edge k; a write with full_o high SHALL be dropped and raise overflow_o after edge k, unless a pop occurs at the same edge, in which case it SHALL be accepted.
REQ-018 FSM states SHALL be IDLE, START, DATA, PARITY, STOP1, STOP2.
REQ-019 In IDLE with the FIFO non-empty, the FSM SHALL pop at the next edge, enter START, and drive serial_o low and busy_o high after that edge.
REQ-020 At the pop, the FSM SHALL latch data_bits_i, parity_bit_i, parity_even_i, two_stop_bits_i and clock_divider_i; input changes mid-frame SHALL have no effect until the next frame.
REQ-021 Each state except IDLE SHALL last exactly clock_divider_i+1 clocks (the latched value); divider 0 gives 1 clock per bit.
REQ-022 Transitions: START->DATA; DATA->DATA until the last bit; then ->PARITY if parity is enabled, else ->STOP1; STOP1->STOP2 if two stop bits are selected; the last stop state goes ->START (FIFO non-empty, no idle gap, busy_o stays high) or ->IDLE.
REQ-023 A data_bits_i value below 5 SHALL be treated as 5; a value above DATA_BITS_MAX SHALL be treated as DATA_BITS_MAX; data bits above the width SHALL be ignored.
REQ-024 The parity bit SHALL be the XOR of the transmitted data bits when even parity is selected, and its inverse when odd parity is selected.
REQ-025 busy_o SHALL fall on the same edge that the FSM enters IDLE; serial_o SHALL be high in IDLE, STOP1 and STOP2.
REQ-026 serial_o and busy_o SHALL be registered outputs (glitch-free).

Reset
REQ-027 While reset_ni is low: serial_o=1, busy_o=0, empty_o=1, full_o=0, level_o=0, overflow_o=0, FSM=IDLE, FIFO emptied; these values SHALL apply asynchronously.
REQ-028 Reset mid-frame SHALL abort the frame immediately, with the line returning high and no further bits sent.

Structure
REQ-029 Package uart_pkg SHALL hold the FSM state enum, the bit-counter width, and the DATA_BITS_MIN=5 constant.
REQ-030 The FIFO SHALL be a separate sub-module, uart_fifo (parameters WIDTH and DEPTH; push/pop, full, empty, level).

Verification
REQ-031 Single frame: divider=1, 8 bits, parity on and even, 2 stop bits, send 0x55. serial_o SHALL be 0,1,0,1,0,1,0,1,0,0,1,1, with 2 clocks per bit and 24 clocks total; busy_o SHALL go low afterwards.
REQ-032 5-bit odd parity: divider=0, send 0x1F with 1 stop bit. serial_o SHALL be 0,1,1,1,1,1,0,1 (parity bit 0).
REQ-033 Back-to-back: push 0xA5 and 0x3C, divider=3. The second start bit SHALL follow the first stop bit with no idle clock, and busy_o SHALL stay high throughout.
REQ-034 Overflow: FIFO_DEPTH=8, divider=100, write on 10 consecutive clocks. 9 words SHALL be accepted, overflow_o SHALL pulse once on the 10th write, and 9 frames SHALL be sent.
REQ-035 Reset mid-frame: assert reset_ni low during data bit 3. serial_o SHALL be 1 and busy_o 0 immediately; no frame SHALL start after release until a new write.
REQ-036 Configuration latch: change data_bits_i from 8 to 5 during a frame. The current frame SHALL still send 8 bits and the next frame SHALL send 5.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter with FIFO.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP1  = 3'd4,
      ST_STOP2  = 3'd5
   } tx_state_e;

   // Wide enough to hold a character width up to 9 and index its bits
   localparam int unsigned BIT_CNT_W     = 4;
   localparam int unsigned DATA_BITS_MIN = 5;
   localparam int unsigned DIV_W         = 16;

   // Character width forced into the range [DATA_BITS_MIN, max_bits]
   function automatic logic [BIT_CNT_W-1:0] clamp_bits(
      input logic [BIT_CNT_W-1:0] req,
      input logic [BIT_CNT_W-1:0] max_bits
   );
      logic [BIT_CNT_W-1:0] res;
      res = req;
      if (req < BIT_CNT_W'(DATA_BITS_MIN)) begin
         res = BIT_CNT_W'(DATA_BITS_MIN);
      end else if (req > max_bits) begin
         res = max_bits;
      end
      return res;
   endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with registered occupancy flags and a one-clock drop pulse.
module uart_fifo #(
   parameter int unsigned WIDTH = 9,
   parameter int unsigned DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic [WIDTH-1:0]       wr_data,
   input  logic                   pop,
   output logic [WIDTH-1:0]       rd_data_c,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level,
   output logic                   overflow
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [LW-1:0]    level_d;
   logic             pop_ok_c;
   logic             push_ok_c;

   // A push into a full FIFO still succeeds when a pop frees a slot at the same edge
   always_comb begin
      pop_ok_c  = pop & ~empty;
      push_ok_c = push & (~full | pop_ok_c);
      level_d   = level;
      case ({push_ok_c, pop_ok_c})
         2'b10:   level_d = level + LW'(1);
         2'b01:   level_d = level - LW'(1);
         default: level_d = level;
      endcase
   end

   // Pointers, occupancy and flags; flags are computed from the next level so they stay registered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level    <= '0;
         full     <= 1'b0;
         empty    <= 1'b1;
         overflow <= 1'b0;
      end else begin
         if (push_ok_c) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_ok_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
         level    <= level_d;
         full     <= (level_d == LW'(DEPTH));
         empty    <= (level_d == '0);
         overflow <= push & ~push_ok_c;
      end
   end

   // Storage array; contents need no reset since empty guards every read
   always_ff @(posedge clk) begin
      if (push_ok_c) mem_q[wr_ptr_q] <= wr_data;
   end

   assign rd_data_c = mem_q[rd_ptr_q];

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a FIFO; frame format is captured per character at the pop.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS_MAX = 9,
   parameter int unsigned FIFO_DEPTH    = 8
) (
   input  logic                        clock_i,
   input  logic                        reset_ni,
   input  logic                        write_i,
   input  logic [DATA_BITS_MAX-1:0]    data_i,
   input  logic [3:0]                  data_bits_i,
   input  logic                        parity_bit_i,
   input  logic                        parity_even_i,
   input  logic                        two_stop_bits_i,
   input  logic [15:0]                 clock_divider_i,
   output logic                        serial_o,
   output logic                        busy_o,
   output logic                        full_o,
   output logic                        empty_o,
   output logic [$clog2(FIFO_DEPTH):0] level_o,
   output logic                        overflow_o
);

   tx_state_e                state_q, state_d;
   logic [DIV_W-1:0]         div_q, div_d;
   logic [DIV_W-1:0]         cnt_q, cnt_d;
   logic [BIT_CNT_W-1:0]     nbits_q, nbits_d;
   logic [BIT_CNT_W-1:0]     bit_q, bit_d;
   logic [DATA_BITS_MAX-1:0] shift_q, shift_d;
   logic                     par_en_q, par_en_d;
   logic                     par_q, par_d;
   logic                     two_stop_q, two_stop_d;
   logic                     serial_d;
   logic                     busy_d;

   logic                     pop_c;
   logic                     start_frame_c;
   logic                     last_tick_c;
   logic [DATA_BITS_MAX-1:0] fifo_data_c;
   logic [DATA_BITS_MAX-1:0] frame_data_c;
   logic [BIT_CNT_W-1:0]     cfg_bits_c;

   uart_fifo #(
      .WIDTH (DATA_BITS_MAX),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clock_i),
      .rst_n     (reset_ni),
      .push      (write_i),
      .wr_data   (data_i),
      .pop       (pop_c),
      .rd_data_c (fifo_data_c),
      .full      (full_o),
      .empty     (empty_o),
      .level     (level_o),
      .overflow  (overflow_o)
   );

   // Character width for the next frame and the word with unused upper bits cleared
   always_comb begin
      cfg_bits_c   = clamp_bits(data_bits_i, BIT_CNT_W'(DATA_BITS_MAX));
      frame_data_c = '0;
      for (int i = 0; i < int'(DATA_BITS_MAX); i++) begin
         frame_data_c[i] = fifo_data_c[i] & (BIT_CNT_W'(i) < cfg_bits_c);
      end
   end

   // Next-state, datapath and output decode
   always_comb begin
      state_d       = state_q;
      div_d         = div_q;
      cnt_d         = cnt_q;
      nbits_d       = nbits_q;
      bit_d         = bit_q;
      shift_d       = shift_q;
      par_en_d      = par_en_q;
      par_d         = par_q;
      two_stop_d    = two_stop_q;
      pop_c         = 1'b0;
      start_frame_c = 1'b0;
      serial_d      = 1'b1;
      busy_d        = 1'b0;
      last_tick_c   = (cnt_q == div_q);

      if (state_q != ST_IDLE) begin
         cnt_d = last_tick_c ? '0 : cnt_q + DIV_W'(1);
      end

      case (state_q)
         ST_IDLE: begin
            if (!empty_o) start_frame_c = 1'b1;
         end
         ST_START: begin
            if (last_tick_c) begin
               state_d = ST_DATA;
               bit_d   = '0;
            end
         end
         ST_DATA: begin
            if (last_tick_c) begin
               if (bit_q == nbits_q - BIT_CNT_W'(1)) begin
                  state_d = par_en_q ? ST_PARITY : ST_STOP1;
               end else begin
                  bit_d   = bit_q + BIT_CNT_W'(1);
                  shift_d = shift_q >> 1;
               end
            end
         end
         ST_PARITY: begin
            if (last_tick_c) state_d = ST_STOP1;
         end
         ST_STOP1: begin
            if (last_tick_c) begin
               if (two_stop_q)    state_d = ST_STOP2;
               else if (!empty_o) start_frame_c = 1'b1;
               else               state_d = ST_IDLE;
            end
         end
         ST_STOP2: begin
            if (last_tick_c) begin
               if (!empty_o) start_frame_c = 1'b1;
               else          state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Pop the next word and capture the frame format for its whole duration
      if (start_frame_c) begin
         pop_c      = 1'b1;
         state_d    = ST_START;
         cnt_d      = '0;
         div_d      = clock_divider_i;
         nbits_d    = cfg_bits_c;
         par_en_d   = parity_bit_i;
         two_stop_d = two_stop_bits_i;
         shift_d    = frame_data_c;
         par_d      = (^frame_data_c) ^ ~parity_even_i;
      end

      case (state_d)
         ST_START:  serial_d = 1'b0;
         ST_DATA:   serial_d = shift_d[0];
         ST_PARITY: serial_d = par_d;
         default:   serial_d = 1'b1;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and datapath registers; reset aborts any frame and returns the line high
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q    <= ST_IDLE;
         div_q      <= '0;
         cnt_q      <= '0;
         nbits_q    <= BIT_CNT_W'(DATA_BITS_MIN);
         bit_q      <= '0;
         shift_q    <= '0;
         par_en_q   <= 1'b0;
         par_q      <= 1'b0;
         two_stop_q <= 1'b0;
         serial_o   <= 1'b1;
         busy_o     <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         cnt_q      <= cnt_d;
         nbits_q    <= nbits_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         par_en_q   <= par_en_d;
         par_q      <= par_d;
         two_stop_q <= two_stop_d;
         serial_o   <= serial_d;
         busy_o     <= busy_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: table of single frames plus multi-cycle corner sequences.
module tb_uart_tx_fifo;

   logic        clk = 1'b0;
   logic        reset_ni;
   logic        write_i;
   logic [8:0]  data_i;
   logic [3:0]  data_bits_i;
   logic        parity_bit_i;
   logic        parity_even_i;
   logic        two_stop_bits_i;
   logic [15:0] clock_divider_i;
   logic        serial_o;
   logic        busy_o;
   logic        full_o;
   logic        empty_o;
   logic [3:0]  level_o;
   logic        overflow_o;

   int n_checks = 0;
   int n_fail   = 0;

   int   busy_neg = 0;
   int   ovf_cnt  = 0;
   int   fall_cnt = 0;
   logic prev_ser = 1'b1;

   typedef struct {
      logic [8:0]  data;
      logic [3:0]  nbits;
      logic        par;
      logic        even;
      logic        two;
      int          div;
      logic [0:15] seq;
      int          len;
   } vec_t;

   vec_t vecs [6];

   uart_tx_fifo #(
      .DATA_BITS_MAX (9),
      .FIFO_DEPTH    (8)
   ) dut (
      .clock_i         (clk),
      .reset_ni        (reset_ni),
      .write_i         (write_i),
      .data_i          (data_i),
      .data_bits_i     (data_bits_i),
      .parity_bit_i    (parity_bit_i),
      .parity_even_i   (parity_even_i),
      .two_stop_bits_i (two_stop_bits_i),
      .clock_divider_i (clock_divider_i),
      .serial_o        (serial_o),
      .busy_o          (busy_o),
      .full_o          (full_o),
      .empty_o         (empty_o),
      .level_o         (level_o),
      .overflow_o      (overflow_o)
   );

   always #5 clk = ~clk;

   // Free-running observers sampled away from the active edge
   always @(negedge clk) begin
      if (busy_o) busy_neg <= busy_neg + 1;
      if (overflow_o) ovf_cnt <= ovf_cnt + 1;
      if (prev_ser && !serial_o) fall_cnt <= fall_cnt + 1;
      prev_ser <= serial_o;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic set_cfg(input logic [3:0] nb, input logic par, input logic even,
                          input logic two, input int div);
      data_bits_i     = nb;
      parity_bit_i    = par;
      parity_even_i   = even;
      two_stop_bits_i = two;
      clock_divider_i = 16'(div);
   endtask

   // One write at the next rising edge; returns 1 time unit after that edge
   task automatic push(input logic [8:0] d);
      @(negedge clk);
      write_i = 1'b1;
      data_i  = d;
      @(posedge clk);
      #1;
      write_i = 1'b0;
   endtask

   // Called 1 time unit after the edge that entered START; checks every clock of the frame
   task automatic run_frame(input string name, input logic [0:15] seq, input int len, input int div);
      int busy_bad = 0;
      for (int b = 0; b < len; b++) begin
         logic act;
         act = seq[b];
         for (int c = 0; c <= div; c++) begin
            if (serial_o !== seq[b]) act = serial_o;
            if (busy_o !== 1'b1) busy_bad++;
            @(posedge clk);
            #1;
         end
         check($sformatf("%s bit%0d", name, b), 32'(act), 32'(seq[b]));
      end
      check({name, " busy"}, 32'(busy_bad), 32'd0);
   endtask

   task automatic check_idle(input string name);
      check({name, " idle busy"}, 32'(busy_o), 32'd0);
      check({name, " idle line"}, 32'(serial_o), 32'd1);
   endtask

   initial begin
      int snap_busy, snap_ovf, snap_fall, busy_seen, low_seen;

      // data, nbits, par, even, two, div, line sequence (first bit leftmost), length
      vecs[0] = '{9'h055, 4'd8,  1'b1, 1'b1, 1'b1, 1, 16'b0101_0101_0011_0000, 12};
      vecs[1] = '{9'h01F, 4'd5,  1'b1, 1'b0, 1'b0, 0, 16'b0111_1101_0000_0000, 8};
      vecs[2] = '{9'h0A3, 4'd8,  1'b0, 1'b0, 1'b0, 2, 16'b0110_0010_1100_0000, 10};
      vecs[3] = '{9'h1C5, 4'd9,  1'b1, 1'b0, 1'b0, 0, 16'b0101_0001_1101_0000, 12};
      vecs[4] = '{9'h0FE, 4'd3,  1'b1, 1'b1, 1'b1, 1, 16'b0011_1101_1000_0000, 9};
      vecs[5] = '{9'h100, 4'd15, 1'b0, 1'b0, 1'b0, 0, 16'b0000_0000_0110_0000, 11};

      reset_ni = 1'b0;
      write_i  = 1'b0;
      data_i   = '0;
      set_cfg(4'd8, 1'b0, 1'b0, 1'b0, 0);

      repeat (2) @(posedge clk);
      #1;
      check("rst serial", 32'(serial_o), 32'd1);
      check("rst busy", 32'(busy_o), 32'd0);
      check("rst empty", 32'(empty_o), 32'd1);
      check("rst full", 32'(full_o), 32'd0);
      check("rst level", 32'(level_o), 32'd0);
      check("rst overflow", 32'(overflow_o), 32'd0);
      @(negedge clk);
      reset_ni = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Table of single frames
      for (int v = 0; v < 6; v++) begin
         set_cfg(vecs[v].nbits, vecs[v].par, vecs[v].even, vecs[v].two, vecs[v].div);
         push(vecs[v].data);
         check($sformatf("vec%0d level", v), 32'(level_o), 32'd1);
         @(posedge clk);
         #1;
         run_frame($sformatf("vec%0d", v), vecs[v].seq, vecs[v].len, vecs[v].div);
         check_idle($sformatf("vec%0d", v));
         repeat (3) @(posedge clk);
         #1;
      end

      // Back-to-back: second start bit directly after the first stop bit
      set_cfg(4'd8, 1'b0, 1'b0, 1'b0, 3);
      push(9'h0A5);
      push(9'h03C);
      run_frame("b2b first", 16'b0101_0010_1100_0000, 10, 3);
      run_frame("b2b second", 16'b0001_1110_0100_0000, 10, 3);
      check_idle("b2b");
      repeat (3) @(posedge clk);
      #1;

      // Configuration is captured at the pop, so the mid-frame width change hits only frame two
      set_cfg(4'd8, 1'b0, 1'b0, 1'b0, 1);
      push(9'h00F);
      push(9'h00F);
      data_bits_i = 4'd5;
      run_frame("cfg 8bit", 16'b0111_1000_0100_0000, 10, 1);
      run_frame("cfg 5bit", 16'b0111_1010_0000_0000, 7, 1);
      check_idle("cfg");
      repeat (3) @(posedge clk);
      #1;

      // Reset during data bit 3 with another word still queued
      set_cfg(4'd8, 1'b0, 1'b0, 1'b0, 3);
      push(9'h000);
      push(9'h000);
      repeat (18) @(posedge clk);
      #1;
      check("midrst pre line", 32'(serial_o), 32'd0);
      check("midrst pre busy", 32'(busy_o), 32'd1);
      #2;
      reset_ni = 1'b0;
      #1;
      check("midrst line", 32'(serial_o), 32'd1);
      check("midrst busy", 32'(busy_o), 32'd0);
      check("midrst empty", 32'(empty_o), 32'd1);
      check("midrst level", 32'(level_o), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_ni = 1'b1;
      busy_seen = 0;
      low_seen  = 0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk);
         #1;
         if (busy_o) busy_seen++;
         if (!serial_o) low_seen++;
      end
      check("midrst quiet busy", 32'(busy_seen), 32'd0);
      check("midrst quiet line", 32'(low_seen), 32'd0);
      set_cfg(vecs[1].nbits, vecs[1].par, vecs[1].even, vecs[1].two, vecs[1].div);
      push(vecs[1].data);
      @(posedge clk);
      #1;
      run_frame("postrst", vecs[1].seq, vecs[1].len, vecs[1].div);
      check_idle("postrst");
      repeat (3) @(posedge clk);
      #1;

      // Overflow: ten consecutive writes, one word in flight plus eight queued, tenth dropped
      set_cfg(4'd8, 1'b0, 1'b0, 1'b0, 100);
      snap_busy = busy_neg;
      snap_ovf  = ovf_cnt;
      snap_fall = fall_cnt;
      @(negedge clk);
      write_i = 1'b1;
      data_i  = 9'h0FF;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         if (i == 1) check("ovf busy rise", 32'(busy_o), 32'd1);
         if (i == 8) begin
            check("ovf full", 32'(full_o), 32'd1);
            check("ovf level9", 32'(level_o), 32'd8);
            check("ovf not yet", 32'(overflow_o), 32'd0);
         end
         if (i == 9) begin
            check("ovf pulse", 32'(overflow_o), 32'd1);
            check("ovf level10", 32'(level_o), 32'd8);
         end
      end
      write_i = 1'b0;
      @(posedge clk);
      #1;
      check("ovf pulse end", 32'(overflow_o), 32'd0);
      for (int i = 0; i < 20000 && busy_o; i++) begin
         @(posedge clk);
         #1;
      end
      check("ovf drain", 32'(busy_o), 32'd0);
      check("ovf busy clocks", 32'(busy_neg - snap_busy), 32'd9090);
      check("ovf pulse count", 32'(ovf_cnt - snap_ovf), 32'd1);
      check("ovf frames", 32'(fall_cnt - snap_fall), 32'd9);
      check("ovf empty", 32'(empty_o), 32'd1);
      check("ovf level end", 32'(level_o), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached, checks %0d failures %0d", n_checks, n_fail);
      $fatal(1);
   end

endmodule
